// File: rtl/axis_if_pkg.sv
// Shared types and default sizing for the AXI-Stream <-> AIU adapter.
package axis_if_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int IN_DEPTH_DEF  = 8;
   localparam int OUT_DEPTH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      RECV,
      WAIT,
      SEND
   } state_t;

endpackage

// File: rtl/axis_if_in_buf.sv
// Input frame regfile: synchronous write/clear, asynchronous read; clear wins over write.
module axis_if_in_buf
   import axis_if_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = IN_DEPTH_DEF,
   parameter int AW     = $clog2(IN_DEPTH_DEF)
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic              we_i,
   input  logic [AW-1:0]     wadr_i,
   input  logic [DATA_W-1:0] wdat_i,
   input  logic [AW-1:0]     radr_i,
   output logic [DATA_W-1:0] rdat_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[wadr_i] <= wdat_i;
      end
   end

   assign rdat_o = mem_q[radr_i];

endmodule

// File: rtl/axis_interface.sv
// AXIS host <-> AIU adapter: start handshake, receive frame, wait for AIU, stream results; outputs decoded from registered state, m_valid held until m_ready.
// Optional AXIS_IF_EARLY_LAST_EN: an accepted beat with s_last ends the inbound frame early.
module axis_interface
   import axis_if_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int IN_DEPTH  = IN_DEPTH_DEF,
   parameter int OUT_DEPTH = OUT_DEPTH_DEF,
   localparam int IA_W     = $clog2(IN_DEPTH),
   localparam int OA_W     = $clog2(OUT_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_start,
   output logic              ex_startAck,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              waitSt,
   input  logic              waitFin,
   input  logic [IA_W-1:0]   inp_adr,
   output logic [DATA_W-1:0] inp_data,
   output logic [OA_W-1:0]   out_adr,
   input  logic [DATA_W-1:0] out_data
);

   state_t          state_q, state_d;
   logic [IA_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [OA_W-1:0] rd_cnt_q, rd_cnt_d;
   logic            buf_we;
   logic            buf_clr;
   logic            frame_end;
   logic            rd_last;

`ifdef AXIS_IF_EARLY_LAST_EN
   assign frame_end = (wr_cnt_q == IA_W'(IN_DEPTH - 1)) || s_last;
`else
   logic unused_s_last;
   assign unused_s_last = s_last;
   assign frame_end     = (wr_cnt_q == IA_W'(IN_DEPTH - 1));
`endif

   assign rd_last = (rd_cnt_q == OA_W'(OUT_DEPTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      buf_we   = 1'b0;
      buf_clr  = 1'b0;
      unique case (state_q)
         IDLE: if (ex_start) state_d = ACK;
         ACK: begin
            if (!ex_start) begin
               state_d  = RECV;
               wr_cnt_d = '0;
               buf_clr  = 1'b1;
            end
         end
         RECV: begin
            if (s_valid) begin
               buf_we   = 1'b1;
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (frame_end) state_d = WAIT;
            end
         end
         WAIT: begin
            if (waitFin) begin
               state_d  = SEND;
               rd_cnt_d = '0;
            end
         end
         SEND: begin
            if (m_ready) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset also wipes the buffer so a half-received frame never leaks to the AIU.
   axis_if_in_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (IN_DEPTH),
      .AW     (IA_W)
   ) u_in_buf (
      .clk    (clk),
      .clr_i  (buf_clr || !rst_n),
      .we_i   (buf_we),
      .wadr_i (wr_cnt_q),
      .wdat_i (s_data),
      .radr_i (inp_adr),
      .rdat_o (inp_data)
   );

   assign ex_startAck = (state_q == ACK);
   assign s_ready     = (state_q == RECV);
   assign waitSt      = (state_q == WAIT);
   assign m_valid     = (state_q == SEND);
   assign m_last      = (state_q == SEND) && rd_last;
   assign out_adr     = (state_q == SEND) ? rd_cnt_q : '0;
   assign m_data      = out_data;

endmodule

// File: tb/tb_axis_interface.sv
// Scoreboard bench for axis_interface: frame in, AIU readback, result stream, backpressure, mid-frame reset.
module tb_axis_interface;

   localparam int DATA_W = 32;
   localparam int IA_W   = 3;
   localparam int OA_W   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ex_start;
   logic              ex_startAck;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_last;
   logic              m_ready;
   logic              waitSt;
   logic              waitFin;
   logic [IA_W-1:0]   inp_adr;
   logic [DATA_W-1:0] inp_data;
   logic [OA_W-1:0]   out_adr;
   logic [DATA_W-1:0] out_data;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DATA_W-1:0] in_q[$];
   logic [DATA_W:0]   out_q[$];

   always #5 clk = ~clk;

   // AIU output buffer model: word at address a is a+13.
   assign out_data = 32'(out_adr) + 32'd13;

   axis_interface dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_start    (ex_start),
      .ex_startAck (ex_startAck),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_last      (m_last),
      .m_ready     (m_ready),
      .waitSt      (waitSt),
      .waitFin     (waitFin),
      .inp_adr     (inp_adr),
      .inp_data    (inp_data),
      .out_adr     (out_adr),
      .out_data    (out_data)
   );

   task automatic chk(input string tag, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ack"},    33'(ex_startAck), 33'd0);
      chk({tag, "_sready"}, 33'(s_ready),     33'd0);
      chk({tag, "_mvalid"}, 33'(m_valid),     33'd0);
      chk({tag, "_mlast"},  33'(m_last),      33'd0);
      chk({tag, "_waitst"}, 33'(waitSt),      33'd0);
      chk({tag, "_outadr"}, 33'(out_adr),     33'd0);
   endtask

   task automatic start_handshake();
      ex_start = 1'b1;
      step();
      chk("start_ack", 33'(ex_startAck), 33'd1);
      chk("start_sready_lo", 33'(s_ready), 33'd0);
      ex_start = 1'b0;
      step();
      chk("recv_sready", 33'(s_ready), 33'd1);
      chk("recv_ack_lo", 33'(ex_startAck), 33'd0);
   endtask

   initial begin
      int cyc;
      logic [DATA_W:0] exp;
      rst_n    = 1'b0;
      ex_start = 1'b0;
      s_data   = '0;
      s_valid  = 1'b0;
      s_last   = 1'b0;
      m_ready  = 1'b0;
      waitFin  = 1'b0;
      inp_adr  = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      chk("reset_mdata", 33'(m_data), 33'd13);
      chk("reset_inpdata", 33'(inp_data), 33'd0);
      rst_n = 1'b1;
      step();
      chk_idle_outputs("idle");

      start_handshake();

      for (int i = 1; i <= 8; i++) begin
         s_valid = 1'b1;
         s_data  = 32'(i);
         s_last  = (i == 8);
         in_q.push_back(32'(i));
         step();
         s_valid = 1'b0;
         s_last  = 1'b0;
         if (i < 8) begin
            chk("recv_no_wait", 33'(waitSt), 33'd0);
            step();
         end
      end
      chk("frame_waitst", 33'(waitSt), 33'd1);
      chk("frame_sready_lo", 33'(s_ready), 33'd0);

      s_valid = 1'b1;
      s_data  = 32'd99;
      step();
      step();
      s_valid = 1'b0;
      chk("overflow_waitst", 33'(waitSt), 33'd1);

      for (int a = 0; a < 8; a++) begin
         inp_adr = IA_W'(a);
         #1;
         exp = 33'(in_q.pop_front());
         chk("inp_data", 33'(inp_data), exp);
      end
      inp_adr = '0;

      waitFin = 1'b1;
      for (int k = 0; k < 4; k++) out_q.push_back({(k == 3), 32'(k + 13)});
      step();
      waitFin = 1'b0;
      chk("send_mvalid", 33'(m_valid), 33'd1);
      chk("send_waitst_lo", 33'(waitSt), 33'd0);

      for (int k = 0; k < 5; k++) begin
         chk("bp_mvalid", 33'(m_valid), 33'd1);
         chk("bp_mdata", 33'(m_data), 33'd13);
         chk("bp_outadr", 33'(out_adr), 33'd0);
         step();
      end

      cyc = 0;
      while (out_q.size() > 0 && cyc < 50) begin
         m_ready = (cyc % 2 == 0);
         #1;
         if (m_valid && m_ready) begin
            exp = out_q.pop_front();
            chk("out_mdata", 33'(m_data), 33'(exp[DATA_W-1:0]));
            chk("out_mlast", 33'(m_last), 33'(exp[DATA_W]));
         end
         step();
         cyc++;
      end
      m_ready = 1'b0;
      if (out_q.size() > 0) chk("send_timeout", 33'(out_q.size()), 33'd0);
      chk_idle_outputs("after_send");

      start_handshake();
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = 32'(21 + i);
         step();
      end
      s_valid = 1'b0;
      rst_n   = 1'b0;
      step();
      rst_n   = 1'b1;
      step();
      chk_idle_outputs("midreset");
      for (int a = 0; a < 8; a++) begin
         inp_adr = IA_W'(a);
         #1;
         chk("midreset_inpdata", 33'(inp_data), 33'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
